// File: rtl/riscv_mem_pkg.sv
// Shared types and limits for the single-port memory arbiter.
// Fetch and data ports share one memory through this arbiter.
package riscv_mem_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {GNT_IF = 1'b0, GNT_DM = 1'b1} grant_t;

    localparam int NBIT_DEF    = 32;
    localparam int MEM_LAT_MAX = 8;

endpackage

// File: rtl/mem_lat_counter.sv
// Counts the memory latency after a grant.
// done marks the edge at which read data is captured.
module mem_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MEM_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // The counter is loaded with MEM_LAT, so 1 means the capture edge is next.
    assign done = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between fetch and data ports.
// Stalls the core while either of its requests is outstanding.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int NBIT    = NBIT_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req,
    input  logic [NBIT-1:0] if_addr,
    output logic [NBIT-1:0] if_rdata,
    output logic            if_valid,
    input  logic            dm_rd,
    input  logic            dm_wr,
    input  logic [NBIT-1:0] dm_addr,
    input  logic [NBIT-1:0] dm_wdata,
    output logic [NBIT-1:0] dm_rdata,
    output logic            dm_valid,
    output logic            stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [NBIT-1:0] mem_addr,
    output logic [NBIT-1:0] mem_wdata,
    input  logic [NBIT-1:0] mem_rdata
);

    state_t state;
    grant_t last_grant;
    grant_t cur_grant;
    logic   cur_rd;
    logic   dm_req;
    logic   pick_dm;
    logic   load;
    logic   done;

    assign dm_req  = dm_rd | dm_wr;
    // On a tie the port opposite the previous winner takes the memory.
    assign pick_dm = dm_req & (~if_req | (last_grant == GNT_IF));
    assign load    = (state == IDLE) & (if_req | dm_req);
    assign stall   = (if_req & ~if_valid) | (dm_req & ~dm_valid);

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .done (done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= GNT_IF;
            cur_grant  <= GNT_IF;
            cur_rd     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        mem_en     <= 1'b1;
                        mem_addr   <= pick_dm ? dm_addr : if_addr;
                        mem_we     <= pick_dm & dm_wr;
                        mem_wdata  <= pick_dm ? dm_wdata : mem_wdata;
                        cur_grant  <= pick_dm ? GNT_DM : GNT_IF;
                        last_grant <= pick_dm ? GNT_DM : GNT_IF;
                        cur_rd     <= ~(pick_dm & dm_wr);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        if (cur_grant == GNT_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_valid <= 1'b1;
                            if (cur_rd) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model; a second instance exercises a longer memory latency.
module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, dm_rd, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, dm_valid, stall, mem_en, mem_we;

    logic        b_if_req;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_valid, b_dm_valid, b_stall, b_mem_en, b_mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NBIT(32), .MEM_LAT(LAT_A)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.NBIT(32), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .rstn(rstn),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .stall(b_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101;
    endfunction

    // Memory for instance A: data is only presented while the strobe is up.
    logic [31:0] env_mem [16];
    assign mem_rdata = mem_en ? env_mem[mem_addr[5:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_en && mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;

    // Memory for instance B: data appears only in the cycle LAT_B-1 after the strobe cycle.
    logic [31:0] b_env_mem [16];
    logic [2:0]  b_age = 3'd0;
    logic [31:0] b_lat_addr = 32'h0;
    always @(posedge clk) begin
        if (b_mem_en) begin
            b_age      <= 3'd1;
            b_lat_addr <= b_mem_addr;
        end else if (b_age != 3'd0) begin
            b_age <= b_age + 3'd1;
        end
    end
    assign b_mem_rdata = (b_age == 3'(LAT_B - 1)) ? b_env_mem[b_lat_addr[5:2]] : 32'hBAD0_BAD0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Transaction-level reference: which access is in flight and when it finishes.
    logic [31:0] ref_mem [16];
    int          edge_no = 0;
    int          done_at = 0;
    bit          pend = 0;
    bit          m_last_dm = 0;
    bit          m_port_dm = 0;
    bit          m_rd = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] e_if_rdata = 0;
    logic [31:0] e_dm_rdata = 0;

    task automatic model_reset();
        pend = 0; m_last_dm = 0; e_if_rdata = 0; e_dm_rdata = 0;
    endtask

    task automatic step();
        bit          dmreq, e_en, e_ifv, e_dmv, gdm, gwe;
        logic [31:0] ga, gw;
        dmreq = dm_rd | dm_wr;
        e_en = 0; e_ifv = 0; e_dmv = 0; gdm = 0; gwe = 0; ga = 0; gw = dm_wdata;
        edge_no++;
        if (pend && edge_no == done_at) begin
            pend = 0;
            if (!m_port_dm) begin
                e_ifv = 1; e_if_rdata = ref_mem[m_addr[5:2]];
            end else begin
                e_dmv = 1;
                if (m_rd) e_dm_rdata = ref_mem[m_addr[5:2]];
            end
        end else if (!pend && (if_req || dmreq)) begin
            gdm = dmreq && (!if_req || !m_last_dm);
            ga  = gdm ? dm_addr : if_addr;
            gwe = gdm && dm_wr;
            e_en = 1; m_last_dm = gdm; m_port_dm = gdm; m_rd = !gwe; m_addr = ga;
            done_at = edge_no + LAT_A; pend = 1;
            if (gwe) ref_mem[ga[5:2]] = dm_wdata;
        end
        @(posedge clk); #1;
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_addr", mem_addr, ga);
            chk("mem_we", 32'(mem_we), 32'(gwe));
            if (gwe) chk("mem_wdata", mem_wdata, gw);
        end
        chk("if_valid", 32'(if_valid), 32'(e_ifv));
        chk("dm_valid", 32'(dm_valid), 32'(e_dmv));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("dm_rdata", dm_rdata, e_dm_rdata);
        chk("stall", 32'(stall), 32'((if_req & ~e_ifv) | (dmreq & ~e_dmv)));
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic new_dm();
        int k;
        k = $urandom_range(0, 3);
        dm_rd = (k != 1); dm_wr = (k == 1 || k == 3);
        dm_addr = rnd_addr(); dm_wdata = $urandom;
    endtask

    task automatic agents();
        if (if_valid) begin
            if ($urandom_range(0, 1) == 1) if_addr = rnd_addr();
            else if_req = 0;
        end else if (!if_req) begin
            if ($urandom_range(0, 9) < 4) begin if_req = 1; if_addr = rnd_addr(); end
        end else if ($urandom_range(0, 19) == 0) begin
            if_req = 0;
        end
        if (dm_valid) begin
            if ($urandom_range(0, 1) == 1) new_dm();
            else begin dm_rd = 0; dm_wr = 0; end
        end else if (!(dm_rd | dm_wr)) begin
            if ($urandom_range(0, 9) < 4) new_dm();
        end else if ($urandom_range(0, 19) == 0) begin
            dm_rd = 0; dm_wr = 0;
        end
    endtask

    task automatic do_reset();
        rstn = 0;
        @(negedge clk); @(negedge clk);
        rstn = 1;
        model_reset();
    endtask

    initial begin
        logic [31:0] prev;
        rstn = 0;
        if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i]   <= init_word(i);
            b_env_mem[i] <= init_word(i);
            ref_mem[i]    = init_word(i);
        end
        env_mem[1] <= 32'h0010_0093;
        ref_mem[1]  = 32'h0010_0093;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_dm_valid", 32'(dm_valid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall", 32'(stall), 0);
        rstn = 1;
        model_reset();

        // Instruction fetch at address 4.
        if_req = 1; if_addr = 32'h4;
        step();
        chk("t1_addr", mem_addr, 32'h4);
        chk("t1_stall", 32'(stall), 1);
        step();
        chk("t1_valid", 32'(if_valid), 1);
        chk("t1_rdata", if_rdata, 32'h0010_0093);
        if_req = 0;
        step();

        // Write then read back.
        dm_wr = 1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("t2_we", 32'(mem_we), 1);
        step();
        dm_wr = 0; dm_rd = 1;
        step(); step();
        chk("t2_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_rd = 0;
        step();

        // Round robin after reset: DM, IF, DM.
        do_reset();
        if_req = 1; if_addr = 32'h20; dm_rd = 1; dm_addr = 32'h30;
        step(); chk("t3_first_dm", mem_addr, 32'h30);
        step();
        step(); chk("t3_second_if", mem_addr, 32'h20);
        step();
        step(); chk("t3_third_dm", mem_addr, 32'h30);
        if_req = 0;
        step();

        // Read and write together act as a write.
        dm_wr = 1; dm_addr = 32'h8; dm_wdata = 32'h1234;
        prev = e_dm_rdata;
        step(); chk("t6_we", 32'(mem_we), 1);
        step();
        chk("t6_mem", env_mem[2], 32'h1234);
        chk("t6_rdata_kept", dm_rdata, prev);
        dm_rd = 0; dm_wr = 0;
        step();

        // Reset in the middle of a fetch.
        if_req = 1; if_addr = 32'h4;
        step();
        #2 rstn = 0;
        #1;
        chk("t5_mem_en", 32'(mem_en), 0);
        chk("t5_if_valid", 32'(if_valid), 0);
        chk("t5_if_rdata", if_rdata, 0);
        if_req = 0;
        @(negedge clk); @(negedge clk);
        rstn = 1;
        model_reset();
        step(); step();
        if_req = 1; if_addr = 32'h4; dm_rd = 1; dm_addr = 32'h10;
        step(); chk("t5_rr_dm", mem_addr, 32'h10);
        if_req = 0; dm_rd = 0;
        step(); step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step();
            agents();
        end
        if_req = 0; dm_rd = 0; dm_wr = 0;
        step(); step(); step();

        // Longer latency: continuous fetch, one completion every LAT_B+1 cycles.
        do_reset();
        b_if_req = 1; b_if_addr = 32'h0;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk); #1;
            chk("b_mem_en", 32'(b_mem_en), 32'(e % (LAT_B + 1) == 1));
            chk("b_if_valid", 32'(b_if_valid), 32'(e % (LAT_B + 1) == 0));
            if (e % (LAT_B + 1) == 0) begin
                chk("b_if_rdata", b_if_rdata, init_word(e / (LAT_B + 1) - 1));
                b_if_addr = b_if_addr + 32'h4;
            end
        end
        b_if_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
